// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle: stage register indices and flags in,
// stall/flush/forward controls and divider handshake out.
interface hazard_ctrl_if;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jumpregD;
    logic       divE, div_readyE;
    logic       imem_stall, dmem_stall, exceptM;

    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM, flushW;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD;
    logic       div_startE, div_cancel, div_busy;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jumpregD, divE, div_readyE, imem_stall, dmem_stall, exceptM,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
               forwardAE, forwardBE, forwardAD, forwardBD,
               div_startE, div_cancel, div_busy
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jumpregD, divE, div_readyE, imem_stall, dmem_stall, exceptM,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
               forwardAE, forwardBE, forwardAD, forwardBD,
               div_startE, div_cancel, div_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage MIPS-style pipeline: forwarding, load/branch
// interlocks, multi-cycle divider sequencing and exception flushes.
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t state, state_nx;
    logic       flush_pend, flush_pend_nx;
    logic       lwstall, branchstall, divstall;

    // Register $0 is hardwired to zero, so it never matches a producer.
    function automatic logic hit(input logic we, input logic [4:0] dst,
                                 input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        hz.forwardAE = 2'b00;
        hz.forwardBE = 2'b00;
        if (hit(hz.regwriteM, hz.writeregM, hz.rsE))      hz.forwardAE = 2'b10;
        else if (hit(hz.regwriteW, hz.writeregW, hz.rsE)) hz.forwardAE = 2'b01;
        if (hit(hz.regwriteM, hz.writeregM, hz.rtE))      hz.forwardBE = 2'b10;
        else if (hit(hz.regwriteW, hz.writeregW, hz.rtE)) hz.forwardBE = 2'b01;
    end

    assign hz.forwardAD = hit(hz.regwriteM, hz.writeregM, hz.rsD);
    assign hz.forwardBD = hit(hz.regwriteM, hz.writeregM, hz.rtD);

    assign lwstall = hit(hz.memtoregE & hz.regwriteE, hz.writeregE, hz.rsD) |
                     hit(hz.memtoregE & hz.regwriteE, hz.writeregE, hz.rtD);

    assign branchstall = (hz.branchD | hz.jumpregD) &
                         (hit(hz.regwriteE, hz.writeregE, hz.rsD) |
                          hit(hz.regwriteE, hz.writeregE, hz.rtD) |
                          hit(hz.memtoregM, hz.writeregM, hz.rsD) |
                          hit(hz.memtoregM, hz.writeregM, hz.rtD));

    // DONE releases EX so the finished division advances exactly once.
    assign divstall    = ((state == IDLE) & hz.divE) | (state == BUSY);
    assign hz.div_busy = (state == BUSY);

    // Pulses are qualified by rst so none escape while reset is held.
    always_comb begin
        state_nx      = state;
        hz.div_startE = 1'b0;
        hz.div_cancel = 1'b0;
        case (state)
            IDLE: if (hz.divE && !hz.exceptM && !hz.dmem_stall) begin
                state_nx      = BUSY;
                hz.div_startE = rst;
            end
            BUSY: if (hz.exceptM) begin
                state_nx      = IDLE;
                hz.div_cancel = rst;
            end else if (hz.div_readyE) begin
                state_nx      = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A fetch in flight at exception time returns late; keep flushing IF/ID until it lands.
    assign flush_pend_nx = hz.imem_stall ? (flush_pend | hz.exceptM) : 1'b0;

    always_comb begin
        hz.stallF = 1'b0;
        hz.stallD = 1'b0;
        hz.stallE = 1'b0;
        hz.stallM = 1'b0;
        if (!hz.exceptM) begin
            hz.stallF = lwstall | branchstall | divstall | hz.imem_stall | hz.dmem_stall;
            hz.stallD = hz.stallF;
            hz.stallE = divstall | hz.dmem_stall;
            hz.stallM = hz.stallE;
        end
    end

    // Branches have a delay slot, so IF/ID is only flushed on exceptions.
    assign hz.flushD = hz.exceptM | flush_pend;
    assign hz.flushE = hz.exceptM | ((lwstall | branchstall) & ~hz.stallE);
    assign hz.flushM = hz.exceptM;
    assign hz.flushW = hz.exceptM;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_pend <= flush_pend_nx;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed expectations checked with
// immediate assertions at mid-cycle sample points.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if hif ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
        hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
        hif.regwriteE = 1'b0; hif.regwriteM = 1'b0; hif.regwriteW = 1'b0;
        hif.memtoregE = 1'b0; hif.memtoregM = 1'b0;
        hif.branchD = 1'b0; hif.jumpregD = 1'b0;
        hif.divE = 1'b0; hif.div_readyE = 1'b0;
        hif.imem_stall = 1'b0; hif.dmem_stall = 1'b0; hif.exceptM = 1'b0;
    endtask

    // Advance to 2 time units after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_inputs();

        // Reset: combinational rules still apply, pulses stay low.
        hif.divE = 1'b1;
        #1;
        check("rst_div_startE", {1'b0, hif.div_startE}, 2'b00);
        check("rst_div_busy",   {1'b0, hif.div_busy},   2'b00);
        check("rst_div_cancel", {1'b0, hif.div_cancel}, 2'b00);
        check("rst_stallE",     {1'b0, hif.stallE},     2'b01);
        check("rst_flushD",     {1'b0, hif.flushD},     2'b00);
        check("rst_forwardAE",  hif.forwardAE,          2'b00);
        hif.divE = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Load-use: lw $2 in EX, rsD = 2.
        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd2; hif.rsD = 5'd2;
        #1;
        check("lw_stallF", {1'b0, hif.stallF}, 2'b01);
        check("lw_stallD", {1'b0, hif.stallD}, 2'b01);
        check("lw_flushE", {1'b0, hif.flushE}, 2'b01);
        check("lw_stallE", {1'b0, hif.stallE}, 2'b00);
        check("lw_flushD", {1'b0, hif.flushD}, 2'b00);
        hif.dmem_stall = 1'b1;
        #1;
        check("lw_dmem_flushE", {1'b0, hif.flushE}, 2'b00);
        check("lw_dmem_stallM", {1'b0, hif.stallM}, 2'b01);
        hif.dmem_stall = 1'b0;
        tick();
        clear_inputs();
        hif.rsD = 5'd2;
        #1;
        check("lw_next_stallD", {1'b0, hif.stallD}, 2'b00);
        check("lw_next_flushE", {1'b0, hif.flushE}, 2'b00);
        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd0; hif.rsD = 5'd0;
        #1;
        check("lw_r0_stallD", {1'b0, hif.stallD}, 2'b00);
        tick();

        // EX forwarding priority.
        clear_inputs();
        hif.regwriteM = 1'b1; hif.writeregM = 5'd5;
        hif.regwriteW = 1'b1; hif.writeregW = 5'd5;
        hif.rsE = 5'd5; hif.rtE = 5'd5;
        #1;
        check("fwdAE_mem", hif.forwardAE, 2'b10);
        check("fwdBE_mem", hif.forwardBE, 2'b10);
        hif.writeregM = 5'd0;
        #1;
        check("fwdAE_wb", hif.forwardAE, 2'b01);
        check("fwdBE_wb", hif.forwardBE, 2'b01);
        hif.writeregW = 5'd0; hif.rsE = 5'd0;
        #1;
        check("fwdAE_r0", hif.forwardAE, 2'b00);
        tick();

        // Branch compare hazard, then forward from MEM one cycle later.
        clear_inputs();
        hif.branchD = 1'b1; hif.rsD = 5'd3; hif.regwriteE = 1'b1; hif.writeregE = 5'd3;
        #1;
        check("br_stallD",  {1'b0, hif.stallD},  2'b01);
        check("br_flushE",  {1'b0, hif.flushE},  2'b01);
        check("br_flushD",  {1'b0, hif.flushD},  2'b00);
        check("br_fwdAD_e", {1'b0, hif.forwardAD}, 2'b00);
        tick();
        hif.regwriteE = 1'b0; hif.writeregE = 5'd0;
        hif.regwriteM = 1'b1; hif.writeregM = 5'd3;
        #1;
        check("br_fwdAD",  {1'b0, hif.forwardAD}, 2'b01);
        check("br_stallD2", {1'b0, hif.stallD},   2'b00);
        check("br_flushE2", {1'b0, hif.flushE},   2'b00);
        hif.rtD = 5'd3;
        #1;
        check("br_fwdBD", {1'b0, hif.forwardBD}, 2'b01);
        hif.memtoregM = 1'b1; hif.branchD = 1'b0; hif.jumpregD = 1'b1;
        #1;
        check("jr_ldM_stallD", {1'b0, hif.stallD}, 2'b01);
        tick();

        // Divider: dmem_stall blocks the start.
        clear_inputs();
        hif.divE = 1'b1; hif.dmem_stall = 1'b1;
        #1;
        check("div_dmem_start",  {1'b0, hif.div_startE}, 2'b00);
        check("div_dmem_stallE", {1'b0, hif.stallE},     2'b01);
        tick();
        hif.dmem_stall = 1'b0;
        #1;
        check("div_startE", {1'b0, hif.div_startE}, 2'b01);
        check("div_stallE", {1'b0, hif.stallE},     2'b01);
        check("div_busy0",  {1'b0, hif.div_busy},   2'b00);
        tick();
        check("div_start_once", {1'b0, hif.div_startE}, 2'b00);
        check("div_busy1",      {1'b0, hif.div_busy},   2'b01);
        for (int i = 0; i < 31; i++) tick();
        hif.div_readyE = 1'b1;
        #1;
        check("div_ready_stallE", {1'b0, hif.stallE},   2'b01);
        check("div_ready_busy",   {1'b0, hif.div_busy}, 2'b01);
        tick();
        hif.div_readyE = 1'b0;
        #1;
        check("div_done_stallE", {1'b0, hif.stallE},     2'b00);
        check("div_done_busy",   {1'b0, hif.div_busy},   2'b00);
        check("div_done_start",  {1'b0, hif.div_startE}, 2'b00);
        tick();
        #1;
        check("div_idle_start", {1'b0, hif.div_startE}, 2'b01);
        hif.divE = 1'b0;
        tick();

        // Exception while BUSY cancels; ready in the same cycle is ignored.
        hif.divE = 1'b1;
        tick();
        hif.exceptM = 1'b1; hif.div_readyE = 1'b1;
        #1;
        check("exc_cancel", {1'b0, hif.div_cancel}, 2'b01);
        check("exc_flushes", {hif.flushD & hif.flushE, hif.flushM & hif.flushW}, 2'b11);
        check("exc_stallFD", {hif.stallF, hif.stallD}, 2'b00);
        check("exc_stallEM", {hif.stallE, hif.stallM}, 2'b00);
        tick();
        hif.exceptM = 1'b0; hif.div_readyE = 1'b0;
        #1;
        check("exc_cancel_once", {1'b0, hif.div_cancel}, 2'b00);
        check("exc_busy_after",  {1'b0, hif.div_busy},   2'b00);
        check("exc_idle_start",  {1'b0, hif.div_startE}, 2'b01);
        hif.divE = 1'b0;
        tick();

        // Exception during an instruction fetch miss.
        clear_inputs();
        hif.exceptM = 1'b1; hif.imem_stall = 1'b1;
        #1;
        check("fp_c0_flushD", {1'b0, hif.flushD}, 2'b01);
        check("fp_c0_stallF", {1'b0, hif.stallF}, 2'b00);
        tick();
        hif.exceptM = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("fp_c%0d_flushD", i), {1'b0, hif.flushD}, 2'b01);
            tick();
        end
        hif.imem_stall = 1'b0;
        #1;
        check("fp_land_flushD", {1'b0, hif.flushD}, 2'b01);
        check("fp_land_flushE", {1'b0, hif.flushE}, 2'b00);
        tick();
        check("fp_after_flushD", {1'b0, hif.flushD}, 2'b00);

        // Reset mid-division: back to IDLE with no cancel pulse.
        hif.divE = 1'b1;
        tick();
        check("rstdiv_busy", {1'b0, hif.div_busy}, 2'b01);
        hif.exceptM = 1'b1;
        rst = 1'b0;
        #1;
        check("rstdiv_cancel", {1'b0, hif.div_cancel}, 2'b00);
        check("rstdiv_idle",   {1'b0, hif.div_busy},   2'b00);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        check("rstdiv_after", {1'b0, hif.div_busy}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed (5-bit register indices, 2-bit forwarding selects).
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 rsD, rtD, rsE, rtE  in  5 each  source register indices in ID and EX.
REQ-005 writeregE, writeregM, writeregW  in  5 each  destination indices in EX, MEM and WB.
REQ-006 regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  in  1 each  write-back and load flags per stage.
REQ-007 branchD, jumpregD  in  1 each  ID holds a branch or a jr/jalr; the compare is resolved in ID.
REQ-008 divE  in  1  EX holds div/divu.
REQ-009 div_readyE  in  1  divider result valid; single-cycle pulse.
REQ-010 imem_stall, dmem_stall, exceptM  in  1 each  fetch not done, data access not done, exception committed in MEM.
REQ-011 stallF, stallD, stallE, stallM  out  1 each  hold PC and IF/ID, ID/EX, EX/MEM registers.
REQ-012 flushD, flushE, flushM, flushW  out  1 each  zero IF/ID, ID/EX, EX/MEM, MEM/WB registers.
REQ-013 forwardAE, forwardBE  out  2 each  EX operand select: 00 = register file, 10 = MEM, 01 = WB.
REQ-014 forwardAD, forwardBD  out  1 each  ID compare operand taken from MEM.
REQ-015 div_startE, div_cancel, div_busy  out  1 each  start pulse, abort pulse, divider-occupied status.

Function
REQ-016 A match SHALL require a nonzero index: index $0 is never forwarded and never causes a stall.
REQ-017 forwardAE SHALL be 10 if regwriteM and writeregM==rsE; otherwise 01 if regwriteW and writeregW==rsE; otherwise 00. MEM has priority over WB. forwardBE is identical using rtE.
REQ-018 forwardAD SHALL be regwriteM and writeregM==rsD; forwardBD SHALL be the same using rtD.
REQ-019 lwstall SHALL be memtoregE and regwriteE and writeregE equal to rsD or rtD.
REQ-020 branchstall SHALL be (branchD or jumpregD) and one of:
  - regwriteE and writeregE equal to rsD or rtD;
  - memtoregM and writeregM equal to rsD or rtD.
REQ-021 Divider FSM states IDLE, BUSY, DONE; the state is registered.
  - IDLE to BUSY when divE and not exceptM and not dmem_stall; div_startE is 1 for that single cycle.
  - BUSY to DONE on div_readyE.
  - DONE to IDLE unconditionally after one cycle.
REQ-022 divstall SHALL be (IDLE and divE) or BUSY. In DONE divstall is 0, so the division leaves EX exactly once.
REQ-023 div_busy SHALL be 1 exactly when the state is BUSY.
REQ-024 exceptM in BUSY SHALL force IDLE with a one-cycle div_cancel pulse; div_readyE in that same cycle is ignored.
REQ-025 Stall outputs when exceptM=0:
  - stallF = stallD = lwstall or branchstall or divstall or imem_stall or dmem_stall;
  - stallE = stallM = divstall or dmem_stall.
REQ-026 flushE SHALL be (lwstall or branchstall) and not stallE, so a bubble is inserted only when EX advances.
REQ-027 exceptM=1 SHALL force all stall outputs to 0 and flushD, flushE, flushM and flushW to 1 in that cycle.
REQ-028 Pending-flush register flush_pend:
  - set when exceptM and imem_stall;
  - cleared on the first cycle with imem_stall=0;
  - flushD SHALL also be 1 while flush_pend is 1, so the late wrong-path fetch is discarded.
REQ-029 Branch delay slot: a taken branch SHALL NOT flush IF/ID.
REQ-030 All outputs other than div_startE, div_cancel and div_busy SHALL be combinational from inputs and the registered state.

Reset
REQ-031 While rst=0: FSM = IDLE, flush_pend = 0, div_startE = div_cancel = div_busy = 0.
REQ-032 While rst=0: stall, flush and forward outputs SHALL follow the input rules using this reset state.
REQ-033 Reset mid-division SHALL return the FSM to IDLE without a div_cancel pulse.

Verification
REQ-034 lw $2 in EX (writeregE=2, memtoregE=1), rsD=2 -> stallF=stallD=1, flushE=1, stallE=0 for exactly one cycle.
REQ-035 regwriteM=1, writeregM=5, regwriteW=1, writeregW=5, rsE=5 -> forwardAE=10; with writeregM=0 instead -> forwardAE=01.
REQ-036 divE=1 from IDLE -> div_startE pulses once and stallE=1; div_readyE asserted 32 cycles later -> DONE for one cycle with stallE=0, then IDLE.
REQ-037 exceptM during BUSY -> div_cancel=1 for one cycle, all flushes=1, all stalls=0, next state IDLE.
REQ-038 exceptM with imem_stall=1, imem_stall held 3 more cycles -> flushD=1 on all 4 cycles and on the first cycle with imem_stall=0; flushD=0 on the cycle after.
REQ-039 beq in ID with rsD=3, regwriteE=1, writeregE=3 -> branchstall gives stallD=1 and flushE=1; one cycle later, same producer in MEM with regwriteM=1 -> forwardAD=1 and no stall.
